// File: rtl/encoder_pkg.sv
// Shared types and sizes for the encoder round/file sequencer.
package encoder_pkg;

  localparam int FILE_W         = 10;
  localparam int ITER_W         = 5;
  localparam int WDOG_W         = 10;
  localparam int DEF_NUM_ROUNDS = 24;

  localparam logic [3:0] ST_IDLE = 4'd0;
  localparam logic [3:0] ST_CP   = 4'd1;
  localparam logic [3:0] ST_CP_W = 4'd2;
  localparam logic [3:0] ST_RO   = 4'd3;
  localparam logic [3:0] ST_RO_W = 4'd4;
  localparam logic [3:0] ST_PE   = 4'd5;
  localparam logic [3:0] ST_PE_W = 4'd6;
  localparam logic [3:0] ST_RE   = 4'd7;
  localparam logic [3:0] ST_RE_W = 4'd8;
  localparam logic [3:0] ST_RC   = 4'd9;
  localparam logic [3:0] ST_RC_W = 4'd10;
  localparam logic [3:0] ST_DONE = 4'd11;

  typedef enum logic [3:0] {
    S_IDLE = ST_IDLE,
    S_CP   = ST_CP,
    S_CP_W = ST_CP_W,
    S_RO   = ST_RO,
    S_RO_W = ST_RO_W,
    S_PE   = ST_PE,
    S_PE_W = ST_PE_W,
    S_RE   = ST_RE,
    S_RE_W = ST_RE_W,
    S_RC   = ST_RC,
    S_RC_W = ST_RC_W,
    S_DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/encoder_watchdog.sv
// Per-stage wait counter; expired flags the last permitted wait cycle.
module encoder_watchdog
  import encoder_pkg::*;
#(
  parameter int LIMIT = 1023
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired
);

  logic [WDOG_W-1:0] cnt;

  always_ff @(posedge clk) begin
    if (rst || clr) cnt <= '0;
    else if (en)    cnt <= cnt + 1'b1;
  end

  assign expired = en && (cnt == WDOG_W'(LIMIT - 1));

endmodule

// File: rtl/encoder_controller.sv
// Round/file sequencer for the five encoder stages.
// Optional stage watchdog: ENCODER_CTRL_WATCHDOG_EN.
module encoder_controller
  import encoder_pkg::*;
#(
  parameter int NUM_ROUNDS = DEF_NUM_ROUNDS,
  parameter int WDOG_LIMIT = 1023
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [FILE_W-1:0] num_files,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [FILE_W-1:0] file_index,
  output logic [ITER_W-1:0] iteration,
  output logic              CP_start,
  output logic              RO_start,
  output logic              PE_start,
  output logic              RE_start,
  output logic              RC_start,
  input  logic              CP_finish,
  input  logic              RO_finish,
  input  logic              PE_finish,
  input  logic              RE_finish,
  input  logic              RC_finish
);

  state_t            state, next;
  logic [FILE_W-1:0] nfiles;
  logic              wait_st, fin_sel;
  logic              last_rnd, last_file;
  logic              expired, wd_trip;

  // only the finish line of the stage being waited on matters
  always_comb begin
    fin_sel = 1'b0;
    wait_st = 1'b1;
    unique case (state)
      S_CP_W:  fin_sel = CP_finish;
      S_RO_W:  fin_sel = RO_finish;
      S_PE_W:  fin_sel = PE_finish;
      S_RE_W:  fin_sel = RE_finish;
      S_RC_W:  fin_sel = RC_finish;
      default: wait_st = 1'b0;
    endcase
  end

  assign last_rnd  = iteration == ITER_W'(NUM_ROUNDS - 1);
  assign last_file = file_index == nfiles - 1'b1;
  assign wd_trip   = wait_st && !fin_sel && expired;

`ifdef ENCODER_CTRL_WATCHDOG_EN
  logic pulse_st;
  logic error_q;

  assign pulse_st = state inside {S_CP, S_RO, S_PE, S_RE, S_RC};

  encoder_watchdog #(.LIMIT(WDOG_LIMIT)) u_wdog (
    .clk     (clk),
    .rst     (rst),
    .clr     (pulse_st),
    .en      (wait_st),
    .expired (expired)
  );

  always_ff @(posedge clk) begin
    if (rst)                              error_q <= 1'b0;
    else if (state == S_IDLE && start)    error_q <= 1'b0;
    else if (wd_trip)                     error_q <= 1'b1;
  end

  assign error = error_q;
`else
  assign expired = 1'b0;
  assign error   = 1'b0;
`endif

  always_comb begin
    next = state;
    unique case (state)
      S_IDLE: if (start) next = (num_files == '0) ? S_DONE : S_CP;
      S_CP:   next = S_CP_W;
      S_RO:   next = S_RO_W;
      S_PE:   next = S_PE_W;
      S_RE:   next = S_RE_W;
      S_RC:   next = S_RC_W;
      S_CP_W: if (fin_sel) next = S_RO;
      S_RO_W: if (fin_sel) next = S_PE;
      S_PE_W: if (fin_sel) next = S_RE;
      S_RE_W: if (fin_sel) next = S_RC;
      S_RC_W: if (fin_sel) next = (last_rnd && last_file) ? S_DONE : S_CP;
      S_DONE: next = S_IDLE;
      default: next = S_IDLE;
    endcase
    if (wd_trip) next = S_IDLE;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      nfiles     <= '0;
      file_index <= '0;
      iteration  <= '0;
    end else begin
      state <= next;
      if (state == S_IDLE && start && num_files != '0) begin
        nfiles     <= num_files;
        file_index <= '0;
        iteration  <= '0;
      end
      if (state == S_RC_W && fin_sel) begin
        if (!last_rnd) begin
          iteration <= iteration + 1'b1;
        end else if (!last_file) begin
          file_index <= file_index + 1'b1;
          iteration  <= '0;
        end
      end
    end
  end

  assign busy     = state != S_IDLE;
  assign done     = state == S_DONE;
  assign CP_start = state == S_CP;
  assign RO_start = state == S_RO;
  assign PE_start = state == S_PE;
  assign RE_start = state == S_RE;
  assign RC_start = state == S_RC;

endmodule
